// File: rtl/lagarto_dcache_req_arbiter.sv
// Arbiter that lets the load, store and AMO requesters of the Lagarto memory
// stage share one L1 data-cache request channel, with one operation in flight.
// Responses go back to whichever requester owns the operation. Responses that
// belong to a killed load/AMO are discarded.

module lagarto_dcache_req_arbiter #(
    parameter int PADDR_W    = 40,
    parameter int STARVE_MAX = 8
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               kill_i,

    input  logic               ld_req_valid_i,
    output logic               ld_req_ready_o,
    input  logic [PADDR_W-1:0] ld_req_addr_i,
    input  logic [1:0]         ld_req_size_i,

    input  logic               st_req_valid_i,
    output logic               st_req_ready_o,
    input  logic [PADDR_W-1:0] st_req_addr_i,
    input  logic [63:0]        st_req_wdata_i,
    input  logic [7:0]         st_req_be_i,
    input  logic [1:0]         st_req_size_i,

    input  logic               amo_req_valid_i,
    output logic               amo_req_ready_o,
    input  logic [3:0]         amo_req_op_i,
    input  logic [PADDR_W-1:0] amo_req_addr_i,
    input  logic [63:0]        amo_req_operand_i,
    input  logic [1:0]         amo_req_size_i,

    output logic               mem_req_valid_o,
    input  logic               mem_req_gnt_i,
    output logic [1:0]         mem_req_type_o,
    output logic [PADDR_W-1:0] mem_req_addr_o,
    output logic [63:0]        mem_req_wdata_o,
    output logic [7:0]         mem_req_be_o,
    output logic [1:0]         mem_req_size_o,
    output logic [3:0]         mem_req_amo_op_o,

    input  logic               mem_resp_valid_i,
    input  logic [63:0]        mem_resp_data_i,

    output logic               ld_resp_valid_o,
    output logic               amo_resp_valid_o,
    output logic [63:0]        resp_data_o,
    output logic               st_done_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    localparam logic [1:0] TYPE_LD  = 2'd0;
    localparam logic [1:0] TYPE_ST  = 2'd1;
    localparam logic [1:0] TYPE_AMO = 2'd2;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    state_t             state_q, state_d;
    logic [1:0]         type_q, type_d;
    logic [PADDR_W-1:0] addr_q, addr_d;
    logic [63:0]        wdata_q, wdata_d;
    logic [7:0]         be_q, be_d;
    logic [1:0]         size_q, size_d;
    logic [3:0]         amo_op_q, amo_op_d;
    logic [7:0]         starve_q, starve_d;
    logic               st_done_q, st_done_d;

    logic sel_ld, sel_st, sel_amo;
    logic resp_ld, resp_amo;

    // Fixed-priority pick of one winner while idle: AMO, starved store, load, store.
    always_comb begin
        sel_ld  = 1'b0;
        sel_st  = 1'b0;
        sel_amo = 1'b0;
        if (state_q == IDLE) begin
            if (amo_req_valid_i && !kill_i) begin
                sel_amo = 1'b1;
            end else if (st_req_valid_i && (starve_q >= STARVE_LIM)) begin
                sel_st = 1'b1;
            end else if (ld_req_valid_i && !kill_i) begin
                sel_ld = 1'b1;
            end else if (st_req_valid_i) begin
                sel_st = 1'b1;
            end
        end
    end

    assign ld_req_ready_o  = sel_ld;
    assign st_req_ready_o  = sel_st;
    assign amo_req_ready_o = sel_amo;

    // Next-state logic: payload capture, handshake with the cache, kill handling.
    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        size_d    = size_q;
        amo_op_d  = amo_op_q;
        starve_d  = starve_q;
        st_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel_amo) begin
                    type_d   = TYPE_AMO;
                    addr_d   = amo_req_addr_i;
                    wdata_d  = amo_req_operand_i;
                    be_d     = 8'h00;
                    size_d   = amo_req_size_i;
                    amo_op_d = amo_req_op_i;
                    state_d  = REQ;
                end else if (sel_st) begin
                    type_d   = TYPE_ST;
                    addr_d   = st_req_addr_i;
                    wdata_d  = st_req_wdata_i;
                    be_d     = st_req_be_i;
                    size_d   = st_req_size_i;
                    amo_op_d = 4'h0;
                    state_d  = REQ;
                end else if (sel_ld) begin
                    type_d   = TYPE_LD;
                    addr_d   = ld_req_addr_i;
                    wdata_d  = 64'h0;
                    be_d     = 8'h00;
                    size_d   = ld_req_size_i;
                    amo_op_d = 4'h0;
                    state_d  = REQ;
                end

                if (sel_st) begin
                    starve_d = 8'h00;
                end else if (st_req_valid_i && (starve_q != 8'hFF)) begin
                    starve_d = starve_q + 8'h01;
                end
            end

            REQ: begin
                if (type_q == TYPE_ST) begin
                    if (mem_req_gnt_i) begin
                        st_done_d = 1'b1;
                        state_d   = IDLE;
                    end
                end else begin
                    if (mem_req_gnt_i && kill_i) begin
                        state_d = DISCARD;
                    end else if (mem_req_gnt_i) begin
                        state_d = WAIT;
                    end else if (kill_i) begin
                        state_d = IDLE;
                    end
                end
            end

            WAIT: begin
                if (mem_resp_valid_i) begin
                    state_d = IDLE;
                end else if (kill_i) begin
                    state_d = DISCARD;
                end
            end

            DISCARD: begin
                if (mem_resp_valid_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched payload and starvation counter; reset abandons any operation.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            type_q    <= 2'd0;
            addr_q    <= '0;
            wdata_q   <= 64'h0;
            be_q      <= 8'h00;
            size_q    <= 2'd0;
            amo_op_q  <= 4'h0;
            starve_q  <= 8'h00;
            st_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            size_q    <= size_d;
            amo_op_q  <= amo_op_d;
            starve_q  <= starve_d;
            st_done_q <= st_done_d;
        end
    end

    assign mem_req_valid_o  = (state_q == REQ);
    assign mem_req_type_o   = type_q;
    assign mem_req_addr_o   = addr_q;
    assign mem_req_wdata_o  = wdata_q;
    assign mem_req_be_o     = be_q;
    assign mem_req_size_o   = size_q;
    assign mem_req_amo_op_o = amo_op_q;

    // Responses are forwarded in the same cycle, only while waiting on a live operation.
    always_comb begin
        resp_ld  = 1'b0;
        resp_amo = 1'b0;
        if ((state_q == WAIT) && mem_resp_valid_i) begin
            resp_ld  = (type_q == TYPE_LD);
            resp_amo = (type_q == TYPE_AMO);
        end
    end

    assign ld_resp_valid_o  = resp_ld;
    assign amo_resp_valid_o = resp_amo;
    assign resp_data_o      = (resp_ld || resp_amo) ? mem_resp_data_i : 64'h0;
    assign st_done_o        = st_done_q;
    assign busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_lagarto_dcache_req_arbiter.sv
// Directed bench for lagarto_dcache_req_arbiter: load/store/AMO flows,
// store anti-starvation, kill in each state and asynchronous reset.

module tb_lagarto_dcache_req_arbiter;

    localparam int PADDR_W = 40;

    logic               clk_i;
    logic               rstn_i;
    logic               kill_i;
    logic               ld_req_valid_i;
    logic               ld_req_ready_o;
    logic [PADDR_W-1:0] ld_req_addr_i;
    logic [1:0]         ld_req_size_i;
    logic               st_req_valid_i;
    logic               st_req_ready_o;
    logic [PADDR_W-1:0] st_req_addr_i;
    logic [63:0]        st_req_wdata_i;
    logic [7:0]         st_req_be_i;
    logic [1:0]         st_req_size_i;
    logic               amo_req_valid_i;
    logic               amo_req_ready_o;
    logic [3:0]         amo_req_op_i;
    logic [PADDR_W-1:0] amo_req_addr_i;
    logic [63:0]        amo_req_operand_i;
    logic [1:0]         amo_req_size_i;
    logic               mem_req_valid_o;
    logic               mem_req_gnt_i;
    logic [1:0]         mem_req_type_o;
    logic [PADDR_W-1:0] mem_req_addr_o;
    logic [63:0]        mem_req_wdata_o;
    logic [7:0]         mem_req_be_o;
    logic [1:0]         mem_req_size_o;
    logic [3:0]         mem_req_amo_op_o;
    logic               mem_resp_valid_i;
    logic [63:0]        mem_resp_data_i;
    logic               ld_resp_valid_o;
    logic               amo_resp_valid_o;
    logic [63:0]        resp_data_o;
    logic               st_done_o;
    logic               busy_o;

    int checks   = 0;
    int failures = 0;

    lagarto_dcache_req_arbiter #(
        .PADDR_W   (PADDR_W),
        .STARVE_MAX(2)
    ) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .kill_i           (kill_i),
        .ld_req_valid_i   (ld_req_valid_i),
        .ld_req_ready_o   (ld_req_ready_o),
        .ld_req_addr_i    (ld_req_addr_i),
        .ld_req_size_i    (ld_req_size_i),
        .st_req_valid_i   (st_req_valid_i),
        .st_req_ready_o   (st_req_ready_o),
        .st_req_addr_i    (st_req_addr_i),
        .st_req_wdata_i   (st_req_wdata_i),
        .st_req_be_i      (st_req_be_i),
        .st_req_size_i    (st_req_size_i),
        .amo_req_valid_i  (amo_req_valid_i),
        .amo_req_ready_o  (amo_req_ready_o),
        .amo_req_op_i     (amo_req_op_i),
        .amo_req_addr_i   (amo_req_addr_i),
        .amo_req_operand_i(amo_req_operand_i),
        .amo_req_size_i   (amo_req_size_i),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_gnt_i    (mem_req_gnt_i),
        .mem_req_type_o   (mem_req_type_o),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_req_wdata_o  (mem_req_wdata_o),
        .mem_req_be_o     (mem_req_be_o),
        .mem_req_size_o   (mem_req_size_o),
        .mem_req_amo_op_o (mem_req_amo_op_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_data_i  (mem_resp_data_i),
        .ld_resp_valid_o  (ld_resp_valid_o),
        .amo_resp_valid_o (amo_resp_valid_o),
        .resp_data_o      (resp_data_o),
        .st_done_o        (st_done_o),
        .busy_o           (busy_o)
    );

    // Free-running clock, period 10
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Absolute time limit so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Move to just after the next rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive the handshake controls for this cycle and let combinational outputs settle
    task automatic applyStimulus(input logic ldV, input logic stV, input logic amoV,
                                 input logic kill, input logic gnt, input logic respV);
        ld_req_valid_i   = ldV;
        st_req_valid_i   = stV;
        amo_req_valid_i  = amoV;
        kill_i           = kill;
        mem_req_gnt_i    = gnt;
        mem_resp_valid_i = respV;
        #1;
    endtask

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Directed sequence
    initial begin
        rstn_i            = 1'b0;
        ld_req_addr_i     = '0;
        ld_req_size_i     = 2'd0;
        st_req_addr_i     = '0;
        st_req_wdata_i    = 64'h0;
        st_req_be_i       = 8'h00;
        st_req_size_i     = 2'd0;
        amo_req_op_i      = 4'h0;
        amo_req_addr_i    = '0;
        amo_req_operand_i = 64'h0;
        amo_req_size_i    = 2'd0;
        mem_resp_data_i   = 64'h0;
        applyStimulus(0, 0, 0, 0, 0, 0);

        $display("[TB] reset state");
        checkOutput("rst_busy", 64'(busy_o), 64'h0);
        checkOutput("rst_mem_req_valid", 64'(mem_req_valid_o), 64'h0);
        checkOutput("rst_st_done", 64'(st_done_o), 64'h0);
        checkOutput("rst_resp_data", resp_data_o, 64'h0);
        checkOutput("rst_mem_req_addr", 64'(mem_req_addr_o), 64'h0);
        tick();
        rstn_i = 1'b1;

        $display("[TB] simple load");
        ld_req_addr_i = 40'h0080001000;
        ld_req_size_i = 2'd3;
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("ld1_ready", 64'(ld_req_ready_o), 64'h1);
        checkOutput("ld1_idle_busy", 64'(busy_o), 64'h0);
        checkOutput("ld1_idle_memvalid", 64'(mem_req_valid_o), 64'h0);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("ld1_memvalid", 64'(mem_req_valid_o), 64'h1);
        checkOutput("ld1_type", 64'(mem_req_type_o), 64'h0);
        checkOutput("ld1_addr", 64'(mem_req_addr_o), 64'h80001000);
        checkOutput("ld1_size", 64'(mem_req_size_o), 64'h3);
        checkOutput("ld1_be", 64'(mem_req_be_o), 64'h0);
        checkOutput("ld1_ready_req", 64'(ld_req_ready_o), 64'h0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("ld1_wait_memvalid", 64'(mem_req_valid_o), 64'h0);
        checkOutput("ld1_wait_busy", 64'(busy_o), 64'h1);
        checkOutput("ld1_wait_noresp", 64'(ld_resp_valid_o), 64'h0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        mem_resp_data_i = 64'hDEADBEEF;
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("ld1_resp_valid", 64'(ld_resp_valid_o), 64'h1);
        checkOutput("ld1_amo_resp", 64'(amo_resp_valid_o), 64'h0);
        checkOutput("ld1_resp_data", resp_data_o, 64'hDEADBEEF);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("ld1_done_busy", 64'(busy_o), 64'h0);
        checkOutput("ld1_done_resp", 64'(ld_resp_valid_o), 64'h0);
        checkOutput("ld1_done_data", resp_data_o, 64'h0);

        $display("[TB] store starvation with load held valid");
        ld_req_addr_i  = 40'h100;
        ld_req_size_i  = 2'd2;
        st_req_addr_i  = 40'h200;
        st_req_wdata_i = 64'h1122334455667788;
        st_req_be_i    = 8'hFF;
        st_req_size_i  = 2'd3;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 1, 0, 0, 0, 0);
            checkOutput("stv_ld_ready", 64'(ld_req_ready_o), 64'h1);
            checkOutput("stv_st_ready", 64'(st_req_ready_o), 64'h0);
            tick();
            applyStimulus(1, 1, 0, 0, 1, 0);
            checkOutput("stv_ld_type", 64'(mem_req_type_o), 64'h0);
            checkOutput("stv_ld_addr", 64'(mem_req_addr_o), 64'h100);
            tick();
            mem_resp_data_i = 64'h11 + 64'(i);
            applyStimulus(1, 1, 0, 0, 0, 1);
            checkOutput("stv_ld_resp", 64'(ld_resp_valid_o), 64'h1);
            tick();
        end
        applyStimulus(1, 1, 0, 0, 0, 0);
        checkOutput("stv_forced_st_ready", 64'(st_req_ready_o), 64'h1);
        checkOutput("stv_forced_ld_ready", 64'(ld_req_ready_o), 64'h0);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("stv_st_type", 64'(mem_req_type_o), 64'h1);
        checkOutput("stv_st_addr", 64'(mem_req_addr_o), 64'h200);
        checkOutput("stv_st_wdata", mem_req_wdata_o, 64'h1122334455667788);
        checkOutput("stv_st_be", 64'(mem_req_be_o), 64'hFF);
        checkOutput("stv_st_done_early", 64'(st_done_o), 64'h0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("stv_st_done", 64'(st_done_o), 64'h1);
        checkOutput("stv_st_busy", 64'(busy_o), 64'h0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("stv_st_done_pulse", 64'(st_done_o), 64'h0);

        $display("[TB] AMO beats load");
        amo_req_op_i      = 4'd4;
        amo_req_operand_i = 64'd5;
        amo_req_addr_i    = 40'h2000;
        amo_req_size_i    = 2'd2;
        applyStimulus(1, 0, 1, 0, 0, 0);
        checkOutput("amo_ready", 64'(amo_req_ready_o), 64'h1);
        checkOutput("amo_ld_ready", 64'(ld_req_ready_o), 64'h0);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("amo_type", 64'(mem_req_type_o), 64'h2);
        checkOutput("amo_wdata", mem_req_wdata_o, 64'h5);
        checkOutput("amo_op", 64'(mem_req_amo_op_o), 64'h4);
        checkOutput("amo_addr", 64'(mem_req_addr_o), 64'h2000);
        checkOutput("amo_be", 64'(mem_req_be_o), 64'h0);
        checkOutput("amo_size", 64'(mem_req_size_o), 64'h2);
        tick();
        mem_resp_data_i = 64'h77;
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("amo_resp_valid", 64'(amo_resp_valid_o), 64'h1);
        checkOutput("amo_ld_resp", 64'(ld_resp_valid_o), 64'h0);
        checkOutput("amo_resp_data", resp_data_o, 64'h77);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("amo_done_busy", 64'(busy_o), 64'h0);

        $display("[TB] kill in REQ without grant");
        ld_req_addr_i = 40'h300;
        applyStimulus(1, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("kreq_memvalid", 64'(mem_req_valid_o), 64'h1);
        tick();
        mem_resp_data_i = 64'h33;
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("kreq_memvalid_after", 64'(mem_req_valid_o), 64'h0);
        checkOutput("kreq_busy", 64'(busy_o), 64'h0);
        checkOutput("kreq_no_resp", 64'(ld_resp_valid_o), 64'h0);
        checkOutput("kreq_no_data", resp_data_o, 64'h0);
        tick();

        $display("[TB] kill with grant in REQ");
        ld_req_addr_i = 40'h380;
        applyStimulus(1, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 1, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("kgnt_busy", 64'(busy_o), 64'h1);
        checkOutput("kgnt_memvalid", 64'(mem_req_valid_o), 64'h0);
        tick();
        mem_resp_data_i = 64'h99;
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("kgnt_dropped", 64'(ld_resp_valid_o), 64'h0);
        checkOutput("kgnt_data", resp_data_o, 64'h0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("kgnt_idle", 64'(busy_o), 64'h0);

        $display("[TB] kill in WAIT, late response");
        ld_req_addr_i = 40'h400;
        applyStimulus(1, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("kwait_noresp", 64'(ld_resp_valid_o), 64'h0);
        checkOutput("kwait_busy", 64'(busy_o), 64'h1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        mem_resp_data_i = 64'hBAD;
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("kwait_dropped", 64'(ld_resp_valid_o), 64'h0);
        checkOutput("kwait_data", resp_data_o, 64'h0);
        checkOutput("kwait_busy_discard", 64'(busy_o), 64'h1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("kwait_idle", 64'(busy_o), 64'h0);

        $display("[TB] kill and response together in WAIT");
        ld_req_addr_i = 40'h480;
        applyStimulus(1, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0);
        tick();
        mem_resp_data_i = 64'h55;
        applyStimulus(0, 0, 0, 1, 0, 1);
        checkOutput("kresp_valid", 64'(ld_resp_valid_o), 64'h1);
        checkOutput("kresp_data", resp_data_o, 64'h55);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("kresp_idle", 64'(busy_o), 64'h0);

        $display("[TB] store ignores kill, waits for grant");
        st_req_addr_i  = 40'h500;
        st_req_wdata_i = 64'hCAFE;
        st_req_be_i    = 8'h0F;
        st_req_size_i  = 2'd2;
        ld_req_addr_i  = 40'h510;
        applyStimulus(1, 1, 0, 1, 0, 0);
        checkOutput("skill_st_ready", 64'(st_req_ready_o), 64'h1);
        checkOutput("skill_ld_ready", 64'(ld_req_ready_o), 64'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 1, 0, 0);
            checkOutput("skill_held_valid", 64'(mem_req_valid_o), 64'h1);
            checkOutput("skill_held_addr", 64'(mem_req_addr_o), 64'h500);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("skill_wdata", mem_req_wdata_o, 64'hCAFE);
        checkOutput("skill_be", 64'(mem_req_be_o), 64'h0F);
        checkOutput("skill_done_early", 64'(st_done_o), 64'h0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("skill_done", 64'(st_done_o), 64'h1);
        tick();

        $display("[TB] asynchronous reset during WAIT");
        ld_req_addr_i = 40'h600;
        applyStimulus(1, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("arst_pre_busy", 64'(busy_o), 64'h1);
        #2;
        rstn_i = 1'b0;
        #1;
        checkOutput("arst_busy", 64'(busy_o), 64'h0);
        checkOutput("arst_addr", 64'(mem_req_addr_o), 64'h0);
        checkOutput("arst_type", 64'(mem_req_type_o), 64'h0);
        checkOutput("arst_size", 64'(mem_req_size_o), 64'h0);
        mem_resp_data_i = 64'h66;
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("arst_no_resp", 64'(ld_resp_valid_o), 64'h0);
        checkOutput("arst_no_data", resp_data_o, 64'h0);
        tick();
        rstn_i = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("arst_after_busy", 64'(busy_o), 64'h0);
        checkOutput("arst_after_memvalid", 64'(mem_req_valid_o), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lagarto_dcache_req_arbiter.md
Name: lagarto_dcache_req_arbiter

Overview:
- Shares the single L1 data-cache request channel among three requesters from the Lagarto memory stage: load, store and atomic (AMO).
- Grants one requester at a time and holds the request stable until the cache grants it.
- Routes the cache response back to the owning requester, discarding responses for operations that were killed.
- Sits between the Lagarto dcache interface and the cache subsystem.

Parameters:
PADDR_W, 40, physical address width.
STARVE_MAX, 8, consecutive cycles a pending store may lose arbitration before it is forced to win (range 1..255).

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
kill_i  in  1  pipeline flush; cancels uncommitted load/AMO
ld_req_valid_i  in  1  load request
ld_req_ready_o  out  1  load accepted this cycle
ld_req_addr_i  in  PADDR_W  load physical address
ld_req_size_i  in  2  load size (0=B,1=H,2=W,3=D)
st_req_valid_i  in  1  store request (already committed)
st_req_ready_o  out  1  store accepted this cycle
st_req_addr_i  in  PADDR_W  store address
st_req_wdata_i  in  64  store data
st_req_be_i  in  8  store byte enables
st_req_size_i  in  2  store size
amo_req_valid_i  in  1  AMO request
amo_req_ready_o  out  1  AMO accepted this cycle
amo_req_op_i  in  4  AMO opcode
amo_req_addr_i  in  PADDR_W  AMO address
amo_req_operand_i  in  64  AMO operand
amo_req_size_i  in  2  AMO size (2=W,3=D)
mem_req_valid_o  out  1  request to cache
mem_req_gnt_i  in  1  cache accepts request
mem_req_type_o  out  2  0=load,1=store,2=AMO
mem_req_addr_o  out  PADDR_W  request address
mem_req_wdata_o  out  64  store data or AMO operand
mem_req_be_o  out  8  byte enables (0 for load/AMO)
mem_req_size_o  out  2  request size
mem_req_amo_op_o  out  4  AMO opcode (0 otherwise)
mem_resp_valid_i  in  1  cache response
mem_resp_data_i  in  64  response data
ld_resp_valid_o  out  1  load result valid
amo_resp_valid_o  out  1  AMO result valid
resp_data_o  out  64  result data
st_done_o  out  1  store granted (one-cycle pulse)
busy_o  out  1  state != IDLE

Behaviour:
- States: IDLE, REQ, WAIT, DISCARD. On reset: state IDLE, all outputs and payload registers 0, starvation counter 0.
- Reset mid-operation abandons the operation. The cache subsystem is reset in the same domain.
- IDLE arbitration (combinational, one winner) priority:
  - AMO first.
  - Store if starve count >= STARVE_MAX.
  - Load.
  - Store.
- The winner's ready_o is high in IDLE only. Payload and type are latched on accept; state moves to REQ.
- kill_i high in IDLE forces ld/amo ready low. Store acceptance is unaffected.
- Starve counter:
  - Increments (saturating) each IDLE cycle with st_req_valid_i high and store not selected.
  - Clears on store accept.
- REQ: mem_req_valid_o=1, payload stable until mem_req_gnt_i.
  - Store + gnt: st_done_o pulses next cycle; state goes to IDLE.
  - Load/AMO + gnt, no kill: state goes to WAIT.
  - Load/AMO + gnt + kill_i same cycle: state goes to DISCARD.
  - Load/AMO + kill_i without gnt: state goes to IDLE. mem_req_valid_o is low from the next cycle.
  - Stores are never killed.
- WAIT:
  - mem_resp_valid_i is passed through combinationally: ld_resp_valid_o or amo_resp_valid_o (per latched type) and resp_data_o=mem_resp_data_i, same cycle. State goes to IDLE.
  - kill_i without response: state goes to DISCARD.
  - kill_i and response in the same cycle: response is delivered; state goes to IDLE.
- DISCARD: waits for mem_resp_valid_i, drops it (no resp valid out), then state goes to IDLE.
- mem_resp_valid_i in IDLE/REQ is ignored.
- resp_data_o is 0 when no resp valid is asserted.
- Latency:
  - Accept in cycle N gives mem_req_valid_o in N+1.
  - Store with gnt in N+1 gives st_done_o in N+2, and the next accept is possible in N+2.
- One outstanding operation maximum.

Test Plan:
- Load 0x80001000 size 3; gnt in cycle 2; resp 0xDEADBEEF in cycle 5 -> ld_resp_valid_o=1 in cycle 5, resp_data_o=0xDEADBEEF, busy_o=0 in cycle 6.
- Load and store valid together in IDLE, STARVE_MAX=2, load held valid -> load wins twice; store wins the third arbitration; st_done_o pulses one cycle after its gnt.
- AMO op 4, operand 5, addr 0x2000, with load valid -> AMO accepted first; mem_req_type_o=2, mem_req_wdata_o=5; amo_resp_valid_o on response.
- Load in REQ, gnt held 0, kill_i pulsed -> mem_req_valid_o=0 next cycle, state IDLE, no ld_resp_valid_o.
- Load granted, kill_i in WAIT, response 3 cycles later -> response dropped; busy_o=0 after it.
- Store in REQ with kill_i and gnt=0 for 4 cycles, then gnt -> request held; st_done_o=1 one cycle after gnt; async reset mid-WAIT clears all outputs immediately.
